// File: rtl/mem_access_pkg.sv
// Shared definitions for the load/store access unit: funct3 codes, FSM
// encoding, byte-lane masks and access-classification helpers.
package mem_access_pkg;

  localparam logic [2:0] FU3_B  = 3'd0;
  localparam logic [2:0] FU3_H  = 3'd1;
  localparam logic [2:0] FU3_W  = 3'd2;
  localparam logic [2:0] FU3_BU = 3'd4;
  localparam logic [2:0] FU3_HU = 3'd5;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_RESP  = 3'd3;
  localparam logic [2:0] S_REQ2  = 3'd4;
  localparam logic [2:0] S_WAIT2 = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE  = S_IDLE,
    ST_REQ   = S_REQ,
    ST_WAIT  = S_WAIT,
    ST_RESP  = S_RESP,
    ST_REQ2  = S_REQ2,
    ST_WAIT2 = S_WAIT2
  } state_t;

  localparam logic [7:0] MASK_B = 8'h01;
  localparam logic [7:0] MASK_H = 8'h03;
  localparam logic [7:0] MASK_W = 8'h0F;

  function automatic logic fu3_illegal(input logic [2:0] fu3, input logic we);
    case (fu3)
      FU3_B, FU3_H, FU3_W: return 1'b0;
      FU3_BU, FU3_HU:      return we;
      default:             return 1'b1;
    endcase
  endfunction

  function automatic logic [7:0] size_mask(input logic [2:0] fu3);
    case (fu3[1:0])
      2'd0:    return MASK_B;
      2'd1:    return MASK_H;
      default: return MASK_W;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] fu3, input logic [1:0] off);
    return ((fu3[1:0] == 2'd1) && off[0]) || ((fu3[1:0] == 2'd2) && (off != 2'd0));
  endfunction

  // An access crosses a word when its shifted lane mask spills into the upper nibble.
  function automatic logic is_crossing(input logic [2:0] fu3, input logic [1:0] off);
    logic [7:0] m;
    m = size_mask(fu3) << off;
    return |m[7:4];
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational load aligner: picks the addressed bytes out of a 64-bit
// {hi,lo} buffer and applies sign or zero extension per funct3.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [31:0] lo,
  input  logic [31:0] hi,
  input  logic [1:0]  offset,
  input  logic [2:0]  fu3,
  output logic [31:0] data
);

  logic [31:0] shifted;

  always_comb begin
    shifted = 32'({hi, lo} >> {offset, 3'b000});
    case (fu3)
      FU3_B:   data = {{24{shifted[7]}}, shifted[7:0]};
      FU3_H:   data = {{16{shifted[15]}}, shifted[15:0]};
      FU3_BU:  data = {24'h0, shifted[7:0]};
      FU3_HU:  data = {16'h0, shifted[15:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Multicycle load/store unit with req/gnt/rvalid memory handshake.
// Define MEM_ACCESS_SPLIT_EN to split word-crossing accesses into two beats.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_fu3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_fault,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  state_t            state;
  logic              we_q;
  logic [2:0]        fu3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              fault_q;
  logic [31:0]       lo_q;
  logic [31:0]       hi_word;
  logic              req_bad;
  logic              beat2;
  logic [ADDR_W-1:0] word_addr;
  logic [7:0]        mask8;
  logic [63:0]       wdata64;
  logic [31:0]       load_data;

`ifdef MEM_ACCESS_SPLIT_EN
  logic [31:0] hi_q;
  assign req_bad = fu3_illegal(req_fu3, req_we);
  assign beat2   = (state == ST_REQ2);
  assign hi_word = hi_q;
`else
  assign req_bad = fu3_illegal(req_fu3, req_we) | is_misaligned(req_fu3, req_addr[1:0]);
  assign beat2   = 1'b0;
  assign hi_word = '0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      we_q    <= 1'b0;
      fu3_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      fault_q <= 1'b0;
      lo_q    <= '0;
`ifdef MEM_ACCESS_SPLIT_EN
      hi_q    <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            fu3_q   <= req_fu3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            fault_q <= req_bad;
            lo_q    <= '0;
`ifdef MEM_ACCESS_SPLIT_EN
            hi_q    <= '0;
`endif
            state   <= req_bad ? ST_RESP : ST_REQ;
          end
        end
        ST_REQ: if (mem_gnt) state <= ST_WAIT;
        ST_WAIT: begin
          if (mem_rvalid) begin
            lo_q  <= mem_rdata;
`ifdef MEM_ACCESS_SPLIT_EN
            state <= is_crossing(fu3_q, addr_q[1:0]) ? ST_REQ2 : ST_RESP;
`else
            state <= ST_RESP;
`endif
          end
        end
`ifdef MEM_ACCESS_SPLIT_EN
        ST_REQ2: if (mem_gnt) state <= ST_WAIT2;
        ST_WAIT2: begin
          if (mem_rvalid) begin
            hi_q  <= mem_rdata;
            state <= ST_RESP;
          end
        end
`endif
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};
  assign mask8     = size_mask(fu3_q) << addr_q[1:0];
  assign wdata64   = {32'h0, wdata_q} << {addr_q[1:0], 3'b000};

  assign req_ready = (state == ST_IDLE);
  assign mem_req   = (state == ST_REQ) || beat2;

  // Beat outputs are only meaningful while a request is on the bus; hold them at 0 otherwise.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_be    = '0;
    mem_wdata = '0;
    if (mem_req) begin
      mem_we   = we_q;
      mem_addr = beat2 ? word_addr + ADDR_W'(4) : word_addr;
      if (we_q) begin
        mem_be    = beat2 ? mask8[7:4] : mask8[3:0];
        mem_wdata = beat2 ? wdata64[63:32] : wdata64[31:0];
      end else begin
        mem_be = 4'hF;
      end
    end
  end

  mem_lane_align u_align (
    .lo     (lo_q),
    .hi     (hi_word),
    .offset (addr_q[1:0]),
    .fu3    (fu3_q),
    .data   (load_data)
  );

  assign rsp_valid = (state == ST_RESP);
  assign rsp_fault = rsp_valid & fault_q;
  assign rsp_rdata = (rsp_valid && !we_q && !fault_q) ? load_data : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: byte-level reference model,
// cycle-scheduled memory responder, directed and random accesses.
module tb_mem_access_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_fu3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_fault;
  logic [31:0] rsp_rdata;
  logic        mem_req, mem_gnt, mem_we, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int unsigned checks = 0;
  int unsigned errors = 0;

`ifdef MEM_ACCESS_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  always #5 clock = ~clock;

  mem_access_unit #(.ADDR_W(32)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_fu3(req_fu3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int unsigned size_of(input logic [2:0] f);
    case (f)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic logic model_fault(input logic we, input logic [2:0] f, input logic [31:0] addr);
    logic legal;
    legal = (f == 3'd0) || (f == 3'd1) || (f == 3'd2) || (!we && (f == 3'd4 || f == 3'd5));
    return !legal || (!SPLIT && (addr % size_of(f)) != 0);
  endfunction

  function automatic int unsigned model_beats(input logic [2:0] f, input logic [31:0] addr);
    return (32'(addr[1:0]) + size_of(f) > 4) ? 2 : 1;
  endfunction

  function automatic void model_beat(input logic we, input logic [2:0] f, input logic [31:0] addr,
                                     input logic [31:0] wdata, input int unsigned b,
                                     output logic [31:0] ea, output logic [3:0] ebe,
                                     output logic [31:0] ewd);
    int unsigned off;
    int unsigned sz;
    off = 32'(addr[1:0]);
    sz  = size_of(f);
    ea  = {addr[31:2], 2'b00} + 32'(4 * b);
    ebe = '0;
    ewd = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      int unsigned p;
      p = 4 * b + i;
      if (!we) ebe[i] = 1'b1;
      else begin
        if (p >= off && p < off + sz) ebe[i] = 1'b1;
        if (p >= off && p < off + 4) ewd[8*i +: 8] = wdata[8*(p-off) +: 8];
      end
    end
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f, input logic [1:0] off,
                                             input logic [31:0] w0, input logic [31:0] w1);
    logic [31:0] v;
    logic [7:0]  bt;
    v = '0;
    for (int unsigned i = 0; i < size_of(f); i++) begin
      int unsigned p;
      p = 32'(off) + i;
      if (p < 4) bt = w0[8*p +: 8];
      else       bt = w1[8*(p-4) +: 8];
      v[8*i +: 8] = bt;
    end
    if (f == 3'd0 && v[7])  v[31:8]  = '1;
    if (f == 3'd1 && v[15]) v[31:16] = '1;
    return v;
  endfunction

  // ---------------- stimulus / compare ----------------
  task automatic chk_reset_outputs(input string tag);
    chk({tag, " req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, " rsp_rdata"}, rsp_rdata, 32'd0);
    chk({tag, " rsp_fault"}, 32'(rsp_fault), 32'd0);
    chk({tag, " mem_req"},   32'(mem_req), 32'd0);
    chk({tag, " mem_we"},    32'(mem_we), 32'd0);
    chk({tag, " mem_addr"},  mem_addr, 32'd0);
    chk({tag, " mem_be"},    32'(mem_be), 32'd0);
    chk({tag, " mem_wdata"}, mem_wdata, 32'd0);
  endtask

  task automatic idle_gap(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clock);
      chk("idle req_ready", 32'(req_ready), 32'd1);
      chk("idle rsp_valid", 32'(rsp_valid), 32'd0);
      chk("idle mem_req",   32'(mem_req), 32'd0);
      mem_rvalid = 1'($urandom_range(0, 1));
      mem_rdata  = $urandom;
    end
  endtask

  task automatic run_txn(input logic we, input logic [2:0] f, input logic [31:0] addr,
                         input logic [31:0] wdata,
                         input int unsigned gd0, input int unsigned rd0,
                         input int unsigned gd1, input int unsigned rd1,
                         input logic [31:0] w0, input logic [31:0] w1,
                         output logic [31:0] got_rd, output logic got_flt,
                         output logic [31:0] b0_addr, output logic [3:0] b0_be,
                         output logic [31:0] b0_wd);
    logic        flt;
    int unsigned nb;
    logic [31:0] ea, ewd, exp_rd;
    logic [3:0]  ebe;
    flt     = model_fault(we, f, addr);
    nb      = model_beats(f, addr);
    exp_rd  = (flt || we) ? 32'd0 : model_load(f, addr[1:0], w0, (nb == 2) ? w1 : 32'd0);
    b0_addr = '0; b0_be = '0; b0_wd = '0;

    @(negedge clock);
    chk("pre req_ready", 32'(req_ready), 32'd1);
    chk("pre rsp_valid", 32'(rsp_valid), 32'd0);
    mem_rvalid = 1'b0;
    req_valid  = 1'b1; req_we = we; req_fu3 = f; req_addr = addr; req_wdata = wdata;

    @(negedge clock);
    req_valid = 1'b0; req_we = 1'($urandom); req_fu3 = 3'($urandom_range(0, 7));
    req_addr = $urandom; req_wdata = $urandom;
    chk("busy req_ready", 32'(req_ready), 32'd0);

    if (!flt) begin
      for (int unsigned b = 0; b < nb; b++) begin
        int unsigned gd, rdl;
        gd  = (b == 0) ? gd0 : gd1;
        rdl = (b == 0) ? rd0 : rd1;
        model_beat(we, f, addr, wdata, b, ea, ebe, ewd);
        for (int unsigned k = 0; k <= gd; k++) begin
          if (k > 0 || b > 0) @(negedge clock);
          chk("beat mem_req",   32'(mem_req), 32'd1);
          chk("beat mem_addr",  mem_addr, ea);
          chk("beat mem_be",    32'(mem_be), 32'(ebe));
          chk("beat mem_we",    32'(mem_we), 32'(we));
          if (we) chk("beat mem_wdata", mem_wdata, ewd);
          chk("beat rsp_valid", 32'(rsp_valid), 32'd0);
          chk("beat req_ready", 32'(req_ready), 32'd0);
          if (b == 0 && k == 0) begin
            b0_addr = mem_addr; b0_be = mem_be; b0_wd = mem_wdata;
          end
          mem_gnt    = (k == gd);
          mem_rvalid = (k != gd) && 1'($urandom_range(0, 1));
          mem_rdata  = $urandom;
        end
        for (int unsigned j = 0; j <= rdl; j++) begin
          @(negedge clock);
          mem_gnt = 1'b0;
          chk("wait mem_req",   32'(mem_req), 32'd0);
          chk("wait rsp_valid", 32'(rsp_valid), 32'd0);
          mem_rvalid = (j == rdl);
          mem_rdata  = (j == rdl) ? ((b == 0) ? w0 : w1) : $urandom;
        end
      end
      @(negedge clock);
      mem_rvalid = 1'b0;
    end

    chk("rsp rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp rsp_fault", 32'(rsp_fault), 32'(flt));
    chk("rsp rsp_rdata", rsp_rdata, exp_rd);
    chk("rsp mem_req",   32'(mem_req), 32'd0);
    chk("rsp req_ready", 32'(req_ready), 32'd0);
    got_rd  = rsp_rdata;
    got_flt = rsp_fault;
  endtask

  initial begin
    logic [31:0] rd, ba, bw;
    logic        fl;
    logic [3:0]  bb;

    req_valid = 1'b0; req_we = 1'b0; req_fu3 = '0; req_addr = '0; req_wdata = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

    repeat (2) @(negedge clock);
    chk_reset_outputs("reset");
    reset = 1'b1;

    // hand-computed anchors for the model itself
    chk("model lb",  model_load(3'd0, 2'd3, 32'h80FF_0000, 32'd0), 32'hFFFF_FF80);
    chk("model lhu", model_load(3'd5, 2'd2, 32'h80FF_0000, 32'd0), 32'h0000_80FF);
    chk("model lw split", model_load(3'd2, 2'd2, 32'hAAAA_5555, 32'h1111_2222), 32'h2222_AAAA);

    run_txn(1'b0, 3'd2, 32'h100, 32'd0, 0, 0, 0, 0, 32'hDEAD_BEEF, 32'd0, rd, fl, ba, bb, bw);
    chk("lw 0x100 rdata", rd, 32'hDEAD_BEEF);
    chk("lw 0x100 addr", ba, 32'h100);
    idle_gap(2);
    run_txn(1'b0, 3'd0, 32'h103, 32'd0, 0, 0, 0, 0, 32'h80FF_0000, 32'd0, rd, fl, ba, bb, bw);
    chk("lb 0x103", rd, 32'hFFFF_FF80);
    run_txn(1'b0, 3'd4, 32'h103, 32'd0, 1, 0, 0, 0, 32'h80FF_0000, 32'd0, rd, fl, ba, bb, bw);
    chk("lbu 0x103", rd, 32'h0000_0080);
    run_txn(1'b0, 3'd5, 32'h102, 32'd0, 0, 1, 0, 0, 32'h80FF_0000, 32'd0, rd, fl, ba, bb, bw);
    chk("lhu 0x102", rd, 32'h0000_80FF);
    run_txn(1'b1, 3'd1, 32'h201, 32'h1234, 0, 0, 0, 0, 32'd0, 32'd0, rd, fl, ba, bb, bw);
`ifdef MEM_ACCESS_SPLIT_EN
    chk("sh 0x201 be", 32'(bb), 32'h6);
    chk("sh 0x201 wdata", bw, 32'h0012_3400);
    chk("sh 0x201 addr", ba, 32'h200);
    chk("sh 0x201 fault", 32'(fl), 32'd0);
`else
    chk("sh 0x201 fault", 32'(fl), 32'd1);
`endif
    run_txn(1'b0, 3'd2, 32'h102, 32'd0, 0, 0, 0, 0, 32'hAAAA_5555, 32'h1111_2222, rd, fl, ba, bb, bw);
`ifdef MEM_ACCESS_SPLIT_EN
    chk("lw 0x102 split", rd, 32'h2222_AAAA);
`else
    chk("lw 0x102 fault", 32'(fl), 32'd1);
`endif
    run_txn(1'b0, 3'd2, 32'h180, 32'd0, 3, 2, 0, 0, 32'h1357_9BDF, 32'd0, rd, fl, ba, bb, bw);
    chk("stalled lw", rd, 32'h1357_9BDF);
    idle_gap(3);
    run_txn(1'b1, 3'd4, 32'h40, 32'hFF, 0, 0, 0, 0, 32'd0, 32'd0, rd, fl, ba, bb, bw);
    chk("sbu fault", 32'(fl), 32'd1);
    run_txn(1'b0, 3'd3, 32'h40, 32'd0, 0, 0, 0, 0, 32'd0, 32'd0, rd, fl, ba, bb, bw);
    chk("fu3=3 fault", 32'(fl), 32'd1);

    for (int unsigned n = 0; n < 250; n++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 7) == 0) a = {30'h3FFF_FFFF, a[1:0]};
      run_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom, $urandom, rd, fl, ba, bb, bw);
      idle_gap($urandom_range(0, 2));
    end

    // reset while a load is waiting for its read data
    @(negedge clock);
    mem_rvalid = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_fu3 = 3'd2; req_addr = 32'h300;
    @(negedge clock);
    req_valid = 1'b0; mem_gnt = 1'b1;
    @(negedge clock);
    mem_gnt = 1'b0;
    chk("pre-reset mem_req", 32'(mem_req), 32'd0);
    #2 reset = 1'b0;
    #1 chk_reset_outputs("mid reset");
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clock);
    mem_rvalid = 1'b0;
    reset = 1'b1;
    run_txn(1'b0, 3'd2, 32'h300, 32'd0, 0, 0, 0, 0, 32'h0BAD_F00D, 32'd0, rd, fl, ba, bb, bw);
    chk("post-reset lw", rd, 32'h0BAD_F00D);

    idle_gap(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
